pp_column_accumulator: RTL and testbench
========================================

// Module: pp_column_accumulator
// PURPOSE
//  Downstream consumer of the 9-lane Booth multiplier column bundles (O0..O15).
//  Compresses each column bundle (CSA tree) into a 20-bit signed 9-product sum.
//  Accumulates that sum over a multi-beat window (e.g. input channels of a 3x3 conv)
//  and emits one ACC_W result per window through a valid/ready output.
//  Sits between the multiplier array and the activation/requant stage.
// PARAMETERS
//  ACC_W     32   accumulator/output width, signed two's complement
//  CNT_W     10   beat-counter width (max window length 2^CNT_W-1)
//  CORR      0    20-bit constant added per beat (Booth sign-extension correction)
//  SAT       1    1: saturate accumulator to ACC_W signed range; 0: wrap
// PORTS
//  clk        in   1    single clock, rising edge
//  reset      in   1    synchronous, active-high
//  in_valid   in   1    column bundle valid
//  in_ready   out  1    block accepts bundle this cycle
//  in_first   in   1    beat starts a new window (qualified by in_valid)
//  in_last    in   1    beat closes the window (qualified by in_valid)
//  O15,O14    in   9    column 15/14 bits, weight 2^15/2^14
//  O13,O12    in   18   column bits, weight 2^13/2^12
//  O11..O7    in   36   column bits, weight 2^11..2^7
//  O6         in   45   column bits, weight 2^6
//  O5         in   27   weight 2^5;  O4 in 36 weight 2^4;  O3 in 18 weight 2^3
//  O2         in   27   weight 2^2;  O1 in 9 weight 2^1;   O0 in 18 weight 2^0
//  out_valid  out  1    result valid, held until out_ready
//  out_ready  in   1    downstream accepts result
//  out_data   out  ACC_W  accumulated window sum
//  out_count  out  CNT_W  beats in the window
//  out_sat    out  1    saturation occurred in this window
// BEHAVIOUR
//  - Beat sum S = (sum_k 2^k * popcount(Ok) + CORR) mod 2^20, read as signed 20-bit,
//    sign-extended to ACC_W. Pure arithmetic; bit order inside a column is irrelevant.
//  - Pipeline: S1 registers the CSA sum/carry pair; S2 runs the CPA and adds CORR;
//    S3 updates the accumulator. Each stage has its own valid bit plus first/last tags.
//  - Global advance: adv = !out_valid | out_ready; in_ready = adv & !reset.
//    All stages hold when adv=0. There are no bubbles while adv=1.
//  - S3 on a tagged beat:
//    - first: acc = S, cnt = 1.
//    - otherwise: acc = acc + S, cnt = cnt + 1.
//    - SAT=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set a sticky sat flag.
//  - last: out_data = new acc, out_count = new cnt, out_sat = sticky | this beat.
//    Then out_valid = 1 and the sticky flag clears. first&last on one beat gives out_data = S, count 1.
//  - Latency: last beat accepted at cycle t -> out_valid at t+3 (adv held 1).
//  - A non-first beat with no window open accumulates onto acc (acc=0 after reset).
//  - cnt saturates at 2^CNT_W-1 and never wraps.
//  - Reset values: out_valid=0, out_data=0, out_count=0, out_sat=0, in_ready=0,
//    all stage valids 0, acc=0, cnt=0.
//  - Reset mid-window or mid-stall discards all in-flight beats and any pending result.
//  - out_data/out_count/out_sat are stable while out_valid & !out_ready.
// STRUCTURE
//  - Shared package npu_pkg: PP_COL_W (column width table), SUM_W=20, default CORR, ACC_W.
//  - One sub-module pp_column_csa: combinational tree with 16 columns in and a
//    20-bit sum/carry pair out. It is reusable by other column consumers.
//  - This file holds the S1-S3 registers, the accumulator/saturation logic and the handshake.
// TESTING
//  1. Drive all columns 0, first&last=1, CORR=0 -> out_data=0, out_count=1, 3 cycles later.
//  2. Set O0 all 18 ones and O15 all 9 ones, other columns 0, first&last=1
//     -> out_data = 18 + 9*32768 = 294930 mod 2^20, signed = 294930.
//  3. Send 4-beat window (first on beat0, last on beat3), each beat with O1 all ones
//     (S=18) -> out_data=72, out_count=4.
//  4. Hold out_ready=0 for 5 cycles with a result pending.
//     -> in_ready=0 and out_data stays stable; the next window's beats are not lost.
//  5. SAT=1, ACC_W=20: accumulate positive S until the accumulator would exceed 2^19-1
//     -> out_data=524287, out_sat=1.
//  6. Assert reset for 1 cycle mid-window (after beat 2 of 4).
//     -> no out_valid; a new window after reset yields only its own sum.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU constants: Booth column widths, beat-sum width and accumulator defaults.
package npu_pkg;
  localparam int NUM_COLS  = 16;
  localparam int SUM_W     = 20;
  localparam int NPU_ACC_W = 32;
  localparam logic [SUM_W-1:0] NPU_CORR = '0;

  // Bits per column, index k carries weight 2^k (O0..O15)
  localparam int PP_COL_W [NUM_COLS] = '{18, 9, 27, 18, 36, 27, 45, 36,
                                         36, 36, 36, 36, 18, 18, 9, 9};

  function automatic int pp_col_off(input int k);
    int off = 0;
    for (int i = 0; i < k; i++) off += PP_COL_W[i];
    return off;
  endfunction

  localparam int PP_COLS_W = pp_col_off(NUM_COLS);
endpackage

// File: rtl/pp_column_csa.sv
// Reduces the 16 Booth column bundles to a SUM_W-bit sum/carry pair (mod 2^SUM_W).
module pp_column_csa
  import npu_pkg::*;
(
  input  logic [PP_COLS_W-1:0] i_cols,
  output logic [SUM_W-1:0]     o_sum,
  output logic [SUM_W-1:0]     o_carry
);
  logic [NUM_COLS-1:0][SUM_W-1:0] w_pp;

  for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
    localparam int W   = PP_COL_W[k];
    localparam int OFF = pp_col_off(k);
    logic [W-1:0] w_bits;
    logic [5:0]   w_cnt;

    assign w_bits = i_cols[OFF +: W];
    always_comb begin
      w_cnt = '0;
      for (int i = 0; i < W; i++) w_cnt = w_cnt + 6'(w_bits[i]);
    end
    assign w_pp[k] = SUM_W'(w_cnt) << k;
  end

  // 3:2 compressors fold the 16 weighted column counts into one redundant pair
  always_comb begin
    logic [SUM_W-1:0] s, c, t;
    s = w_pp[0];
    c = w_pp[1];
    t = '0;
    for (int k = 2; k < NUM_COLS; k++) begin
      t = s ^ c ^ w_pp[k];
      c = ((s & c) | (s & w_pp[k]) | (c & w_pp[k])) << 1;
      s = t;
    end
    o_sum   = s;
    o_carry = c;
  end
endmodule

// File: rtl/pp_column_accumulator.sv
// Three-stage column compressor + windowed accumulator with valid/ready result port.
module pp_column_accumulator
  import npu_pkg::*;
#(
  parameter int               ACC_W = NPU_ACC_W,
  parameter int               CNT_W = 10,
  parameter logic [SUM_W-1:0] CORR  = NPU_CORR,
  parameter bit               SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [8:0]       O15,
  input  logic [8:0]       O14,
  input  logic [17:0]      O13,
  input  logic [17:0]      O12,
  input  logic [35:0]      O11,
  input  logic [35:0]      O10,
  input  logic [35:0]      O9,
  input  logic [35:0]      O8,
  input  logic [35:0]      O7,
  input  logic [44:0]      O6,
  input  logic [26:0]      O5,
  input  logic [35:0]      O4,
  input  logic [17:0]      O3,
  input  logic [26:0]      O2,
  input  logic [8:0]       O1,
  input  logic [17:0]      O0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  logic [PP_COLS_W-1:0] w_cols;
  logic [SUM_W-1:0]     w_csa_sum, w_csa_carry;
  logic                 w_adv;

  logic [1:0]           r_vld, r_first, r_last;   // [0]=S1, [1]=S2
  logic [SUM_W-1:0]     r_s1_sum, r_s1_carry, r_s2_beat;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sticky;

  logic [ACC_W-1:0]     w_beat_ext, w_base, w_acc_nxt;
  logic [ACC_W:0]       w_sum_x;
  logic                 w_ovf, w_sat_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  assign w_cols = {O15, O14, O13, O12, O11, O10, O9, O8,
                   O7, O6, O5, O4, O3, O2, O1, O0};

  pp_column_csa u_csa (
    .i_cols  (w_cols),
    .o_sum   (w_csa_sum),
    .o_carry (w_csa_carry)
  );

  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv & !reset;

  // S3: a first beat restarts from zero, anything else extends the running window
  assign w_beat_ext = ACC_W'(signed'(r_s2_beat));
  assign w_base     = r_first[1] ? '0 : r_acc;
  assign w_sum_x    = {w_base[ACC_W-1], w_base} + {w_beat_ext[ACC_W-1], w_beat_ext};
  assign w_ovf      = SAT && (w_sum_x[ACC_W] != w_sum_x[ACC_W-1]);
  assign w_acc_nxt  = !w_ovf         ? w_sum_x[ACC_W-1:0] :
                      w_sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                       {1'b0, {(ACC_W-1){1'b1}}};
  assign w_cnt_nxt  = r_first[1] ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + CNT_W'(1));
  assign w_sat_nxt  = (!r_first[1] & r_sticky) | w_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld      <= '0;
      r_first    <= '0;
      r_last     <= '0;
      r_s1_sum   <= '0;
      r_s1_carry <= '0;
      r_s2_beat  <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sticky   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_sat    <= 1'b0;
    end else if (w_adv) begin
      r_vld      <= {r_vld[0], in_valid};
      r_first    <= {r_first[0], in_first & in_valid};
      r_last     <= {r_last[0], in_last & in_valid};
      r_s1_sum   <= w_csa_sum;
      r_s1_carry <= w_csa_carry;
      r_s2_beat  <= r_s1_sum + r_s1_carry + CORR;
      if (r_vld[1]) begin
        r_acc    <= w_acc_nxt;
        r_cnt    <= w_cnt_nxt;
        r_sticky <= r_last[1] ? 1'b0 : w_sat_nxt;
      end
      out_valid <= r_vld[1] & r_last[1];
      if (r_vld[1] & r_last[1]) begin
        out_data  <= w_acc_nxt;
        out_count <= w_cnt_nxt;
        out_sat   <= w_sat_nxt;
      end
    end
  end
endmodule

// File: tb/tb_pp_column_accumulator.sv
// Directed bench: driver pushes hand-computed window results, monitor pops on each handshake.
module tb_pp_column_accumulator;
  localparam int ACC_W = 20;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_first, in_last;
  logic [8:0]  O15, O14, O1;
  logic [17:0] O13, O12, O3, O0;
  logic [35:0] O11, O10, O9, O8, O7, O4;
  logic [44:0] O6;
  logic [26:0] O5, O2;
  logic out_valid, out_ready, out_sat;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pp_column_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W), .CORR(20'd0), .SAT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .O15(O15), .O14(O14), .O13(O13), .O12(O12), .O11(O11), .O10(O10), .O9(O9), .O8(O8),
    .O7(O7), .O6(O6), .O5(O5), .O4(O4), .O3(O3), .O2(O2), .O1(O1), .O0(O0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // m[k]=1 fills column k with ones; O6/O2 take explicit patterns when their mask bit is clear
  task automatic send(input logic [15:0] m, input logic [44:0] o6, input logic [26:0] o2,
                      input logic f, input logic l, input bit push,
                      input int d, input int c, input bit s);
    int  tmo  = 0;
    bit  done = 0;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      O0 = {18{m[0]}};  O1 = {9{m[1]}};   O2 = m[2] ? '1 : o2;  O3 = {18{m[3]}};
      O4 = {36{m[4]}};  O5 = {27{m[5]}};  O6 = m[6] ? '1 : o6;  O7 = {36{m[7]}};
      O8 = {36{m[8]}};  O9 = {36{m[9]}};  O10 = {36{m[10]}};    O11 = {36{m[11]}};
      O12 = {18{m[12]}}; O13 = {18{m[13]}}; O14 = {9{m[14]}};   O15 = {9{m[15]}};
      in_valid = 1'b1; in_first = f; in_last = l;
      #4;
      if (in_ready) done = 1;
      else if (++tmo > 200) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles want accept", tmo);
        done = 1;
      end
      @(posedge clk);
    end
    if (push) begin
      e.data = ACC_W'(d); e.cnt = CNT_W'(c); e.sat = s;
      exp_q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic b(input logic [15:0] m, input logic f, input logic l);
    send(m, '0, '0, f, l, 0, 0, 0, 0);
  endtask

  task automatic bx(input logic [15:0] m, input logic f, input logic l,
                    input int d, input int c, input bit s);
    send(m, '0, '0, f, l, 1, d, c, s);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 50) begin @(negedge clk); k++; end
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: pops on handshake, checks pending result against scoreboard head while stalled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: got data=0x%0h cnt=%0d want none", out_data, out_count);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_count", out_count, e.cnt);
          chk("out_sat", out_sat, e.sat);
        end else begin
          e = exp_q[0];
          chk("hold_data", out_data, e.data);
          chk("hold_count", out_count, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    {O15, O14, O13, O12, O11, O10, O9, O8} = '0;
    {O7, O6, O5, O4, O3, O2, O1, O0} = '0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk) reset = 1'b0;

    // zero bundle, single-beat window, latency 3
    bx(16'h0000, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4;
      chk("latency", out_valid, (i == 2));
    end

    bx(16'h8001, 1, 1, 294930, 1, 0);              // 18 + 9*32768
    b(16'h0002, 1, 0); b(16'h0002, 0, 0); b(16'h0002, 0, 0);
    bx(16'h0002, 0, 1, 72, 4, 0);                  // 4 x 18
    bx(16'hFFFF, 1, 1, -237568, 1, 0);             // 811008 mod 2^20 read signed
    send(16'h0000, 45'h10_0000_0401, 27'h400_0001, 1, 1, 1, 200, 1, 0);  // 3*64 + 2*4
    wait_drain();

    // backpressure: result held, next window waits without loss
    @(negedge clk) out_ready = 1'b0;
    fork
      begin
        bx(16'h0001, 1, 1, 18, 1, 0);
        b(16'h0002, 1, 0); b(16'h0002, 0, 0);
        bx(16'h0002, 0, 1, 54, 3, 0);
      end
      begin
        int k = 0;
        while (!out_valid && k < 20) begin @(negedge clk); #4; k++; end
        chk("stall_seen", out_valid, 1);
        repeat (5) begin
          @(negedge clk); #4;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_data", out_data, 18);
        end
        @(negedge clk) out_ready = 1'b1;
      end
    join
    wait_drain();

    // saturation, sticky flag, and its clearing on the next window
    b(16'h8001, 1, 0);
    bx(16'h8001, 0, 1, 524287, 2, 1);
    b(16'hFFFF, 1, 0); b(16'hFFFF, 0, 0);
    bx(16'hFFFF, 0, 1, -524288, 3, 1);
    b(16'h8001, 1, 0); b(16'h8001, 0, 0);
    bx(16'hFFFF, 0, 1, 286719, 3, 1);
    bx(16'h0001, 1, 1, 18, 1, 0);
    wait_drain();

    // reset while a result is stalled discards it
    @(negedge clk) out_ready = 1'b0;
    bx(16'h0001, 1, 1, 18, 1, 0);
    repeat (4) @(negedge clk);
    #4 chk("pending_valid", out_valid, 1);
    @(negedge clk) begin reset = 1'b1; exp_q.delete(); end
    @(negedge clk) begin reset = 1'b0; out_ready = 1'b1; end
    #4;
    chk("stall_rst_valid", out_valid, 0);
    chk("stall_rst_data", out_data, 0);
    chk("stall_rst_count", out_count, 0);

    // reset mid-window discards in-flight beats and clears acc/cnt
    b(16'h0002, 1, 0); b(16'h0002, 0, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (5) begin
      @(negedge clk); #4;
      chk("post_rst_idle", out_valid, 0);
    end
    bx(16'h0002, 0, 1, 18, 1, 0);
    bx(16'h8001, 1, 1, 294930, 1, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
